popcount_stream_acc: RTL and testbench
======================================

// Module: popcount_stream_acc
// PURPOSE
//  Multi-beat popcount accumulator for the printed ternary-neuron datapath.
//  - Each beat supplies IN_W activation bits; a frame of 1..BEATS_MAX beats is summed to one count.
//  - Exact successor of the fixed 28-input combinational popcounts: parametrised width, multi-beat
//    frames, valid/ready handshakes, beat counting and overflow flagging.
// PARAMETERS
//  IN_W       28  bits presented per beat
//  BEATS_MAX  16  maximum beats per frame (>=1)
//  ACC_W      $clog2(IN_W*BEATS_MAX+1)  result width (derived; never overridden)
//  BCNT_W     $clog2(BEATS_MAX+1)       beat-counter width (derived)
// PORTS
//  clk            in   1       clock
//  rst            in   1       synchronous reset, active-high
//  in_valid       in   1       beat valid
//  in_ready       out  1       beat accepted when in_valid & in_ready
//  input_a        in   IN_W    positive-weight bits of beat
//  in_last        in   1       final beat of frame
//  out_valid      out  1       result valid
//  out_ready      in   1       result consumed when out_valid & out_ready
//  popcount_out   out  ACC_W   frame count (signed ACC_W+1 with POPCNT_TERNARY_EN)
//  out_beats      out  BCNT_W  beats in frame
//  out_ovf        out  1       frame exceeded BEATS_MAX beats
// BEHAVIOUR
//  - Reset: state=ACC; acc=0; bcnt=0; ovf=0.
//    Outputs after reset: in_ready=1, out_valid=0, popcount_out=0, out_beats=0, out_ovf=0.
//  - State ACC: in_ready=1.
//    Each accepted beat: acc += popcount(input_a), bcnt += 1.
//    If the beat carries in_last:
//      popcount_out <= acc + popcount(input_a); out_beats <= bcnt+1; out_ovf <= ovf;
//      acc, bcnt, ovf cleared; go to HOLD.
//  - State HOLD: out_valid=1, in_ready=0, outputs stable.
//    On out_ready go to ACC in the same edge; in_ready is high the next cycle.
//  - Latency: out_valid rises the cycle after the in_last beat is accepted.
//    Throughput is 1 beat/cycle within a frame, plus 1 bubble cycle per frame (HOLD with out_ready=1).
//  - Overflow: an accepted beat while bcnt==BEATS_MAX and no in_last:
//    beat is dropped (acc and bcnt unchanged), ovf=1.
//    Frame continues until in_last; the in_last beat is also dropped if bcnt==BEATS_MAX.
//    acc therefore never exceeds IN_W*BEATS_MAX, so no wrap-around is possible.
//  - Single-beat frame (in_last on first beat): popcount_out=popcount(input_a), out_beats=1.
//  - in_valid=0 in ACC: no state change.
//    Input fields are ignored when not accepted.
//  - rst mid-frame or in HOLD: partial frame discarded, return to reset state next edge.
//  - Arithmetic is exact, unsigned, zero-extended to ACC_W.
// CONFIGURATION
//  POPCNT_TERNARY_EN defined:
//    - Adds port input_b (in, IN_W), the negative-weight bits of the beat.
//    - Per beat acc += popcount(input_a) - popcount(input_b).
//    - popcount_out becomes signed, width ACC_W+1, two's complement.
//    - Adds port out_sign (out, 1): 1 when the result is <0, reset 0.
//  POPCNT_TERNARY_EN undefined:
//    - No input_b and no out_sign; unsigned ACC_W result as described above.
// STRUCTURE
//  - popcount_pkg:
//      state enum {ST_ACC, ST_HOLD};
//      function pc_width(n) = $clog2(n+1);
//      localparam defaults for IN_W and BEATS_MAX.
//  - Sub-module popcount_tree #(W):
//      combinational exact adder tree, output width pc_width(W);
//      instanced once for input_a, and a second time for input_b under POPCNT_TERNARY_EN.
//  - Top level holds the FSM, accumulator, beat counter and result registers.
// TESTING
//  1. rst held 2 cycles -> in_ready=1, out_valid=0, popcount_out=0, out_beats=0, out_ovf=0.
//  2. One beat input_a=28'hFFFFFFF, in_last=1 -> next cycle out_valid=1, popcount_out=28, out_beats=1.
//  3. Three beats 28'h0000001, 28'h00000FF, 28'hFFFFFFF (last) with out_ready=0 for 5 cycles
//     -> popcount_out=37 held stable, in_ready=0 throughout; out_ready=1 -> in_ready=1 next cycle.
//  4. 17 beats of all-ones, in_last on the 18th -> popcount_out=448, out_beats=16, out_ovf=1.
//     Next frame reports out_ovf=0.
//  5. rst asserted after 2 of 4 beats -> next frame of 1 beat 28'h3 gives popcount_out=2, out_beats=1.
//  6. POPCNT_TERNARY_EN: beats a=28'hF/b=28'hFF, then a=28'h1/b=0 (last)
//     -> popcount_out=-3, out_sign=1.

Source files
------------

// File: rtl/popcount_stream_acc_pkg.sv
// Shared types and sizing helpers for the multi-beat popcount accumulator.
// Also used by popcount_stream_acc_if and popcount_tree.
package popcount_pkg;

  typedef enum logic {ST_ACC, ST_HOLD} state_t;

  localparam int IN_W_DEF      = 28;
  localparam int BEATS_MAX_DEF = 16;

  // Bits needed to hold a count in the range 0..n inclusive.
  function automatic int pc_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/popcount_stream_acc_if.sv
// Beat-in / frame-result handshake bundle for popcount_stream_acc.
// Defining POPCNT_TERNARY_EN adds input_b and out_sign, and widens popcount_out to a signed result.
interface popcount_stream_acc_if import popcount_pkg::*; #(
  parameter int IN_W      = IN_W_DEF,
  parameter int BEATS_MAX = BEATS_MAX_DEF
);
  localparam int ACC_W  = pc_width(IN_W * BEATS_MAX);
  localparam int BCNT_W = pc_width(BEATS_MAX);
`ifdef POPCNT_TERNARY_EN
  localparam int RES_W  = ACC_W + 1;
`else
  localparam int RES_W  = ACC_W;
`endif

  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   input_a;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [RES_W-1:0]  popcount_out;
  logic [BCNT_W-1:0] out_beats;
  logic              out_ovf;
`ifdef POPCNT_TERNARY_EN
  logic [IN_W-1:0]   input_b;
  logic              out_sign;

  modport master (
    output in_valid, input_a, input_b, in_last, out_ready,
    input  in_ready, out_valid, popcount_out, out_beats, out_ovf, out_sign
  );
  modport slave (
    input  in_valid, input_a, input_b, in_last, out_ready,
    output in_ready, out_valid, popcount_out, out_beats, out_ovf, out_sign
  );
`else
  modport master (
    output in_valid, input_a, in_last, out_ready,
    input  in_ready, out_valid, popcount_out, out_beats, out_ovf
  );
  modport slave (
    input  in_valid, input_a, in_last, out_ready,
    output in_ready, out_valid, popcount_out, out_beats, out_ovf
  );
`endif

endinterface

// File: rtl/popcount_stream_acc_tree.sv
// popcount_tree: exact combinational popcount built as a recursive balanced adder tree.
// Each node adds the counts of its two halves, so the depth grows with log2(W).
module popcount_tree import popcount_pkg::*; #(
  parameter int W = 28
) (
  input  logic [W-1:0]           bits,
  output logic [pc_width(W)-1:0] cnt
);
  localparam int OW = pc_width(W);

  if (W == 1) begin : g_leaf
    assign cnt = bits;
  end else begin : g_node
    localparam int WL = W / 2;
    localparam int WH = W - WL;

    logic [pc_width(WL)-1:0] cnt_lo;
    logic [pc_width(WH)-1:0] cnt_hi;

    popcount_tree #(.W(WL)) u_lo (.bits(bits[WL-1:0]), .cnt(cnt_lo));
    popcount_tree #(.W(WH)) u_hi (.bits(bits[W-1:WL]), .cnt(cnt_hi));

    assign cnt = OW'(cnt_lo) + OW'(cnt_hi);
  end

endmodule

// File: rtl/popcount_stream_acc.sv
// popcount_stream_acc: sums per-beat popcounts over a frame of 1..BEATS_MAX beats and holds the result.
// Defining POPCNT_TERNARY_EN subtracts popcount(input_b) per beat and yields a signed result with out_sign.
module popcount_stream_acc import popcount_pkg::*; #(
  parameter int IN_W      = IN_W_DEF,
  parameter int BEATS_MAX = BEATS_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  popcount_stream_acc_if.slave  bus
);
  localparam int ACC_W  = pc_width(IN_W * BEATS_MAX);
  localparam int BCNT_W = pc_width(BEATS_MAX);
  localparam int PC_W   = pc_width(IN_W);
`ifdef POPCNT_TERNARY_EN
  localparam int RES_W  = ACC_W + 1;
  typedef logic signed [RES_W-1:0] sum_t;
`else
  localparam int RES_W  = ACC_W;
  typedef logic [RES_W-1:0] sum_t;
`endif

  logic [PC_W-1:0] pc_a;
  popcount_tree #(.W(IN_W)) u_pc_a (.bits(bus.input_a), .cnt(pc_a));

`ifdef POPCNT_TERNARY_EN
  logic [PC_W-1:0] pc_b;
  popcount_tree #(.W(IN_W)) u_pc_b (.bits(bus.input_b), .cnt(pc_b));

  function automatic sum_t beat_delta(input logic [PC_W-1:0] pos, input logic [PC_W-1:0] neg);
    return sum_t'(pos) - sum_t'(neg);
  endfunction
`else
  function automatic sum_t beat_delta(input logic [PC_W-1:0] pos);
    return sum_t'(pos);
  endfunction
`endif

  state_t            state;
  logic              in_ready_r;
  sum_t              acc_p0;
  logic [BCNT_W-1:0] bcnt_p0;
  logic              ovf_p0;
  sum_t              res_p1;
  logic [BCNT_W-1:0] beats_p1;
  logic              ovf_p1;
  logic              vld_p1;
  logic              sign_p1;

  sum_t              delta;
  sum_t              frame_res;
  logic              accept;
  logic              drop;

`ifdef POPCNT_TERNARY_EN
  assign delta = beat_delta(pc_a, pc_b);
`else
  assign delta = beat_delta(pc_a);
`endif
  assign accept    = bus.in_valid && in_ready_r;
  // A full frame discards further beats, so acc_p0 stays within IN_W*BEATS_MAX.
  assign drop      = (bcnt_p0 == BCNT_W'(BEATS_MAX));
  assign frame_res = drop ? acc_p0 : acc_p0 + delta;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_ACC;
      in_ready_r <= 1'b1;
      acc_p0     <= '0;
      bcnt_p0    <= '0;
      ovf_p0     <= 1'b0;
      res_p1     <= '0;
      beats_p1   <= '0;
      ovf_p1     <= 1'b0;
      vld_p1     <= 1'b0;
      sign_p1    <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (accept) begin
            if (bus.in_last) begin
              // Stage p0 -> p1: close the frame into the result registers.
              res_p1     <= frame_res;
              beats_p1   <= drop ? bcnt_p0 : bcnt_p0 + BCNT_W'(1);
              ovf_p1     <= ovf_p0 | drop;
`ifdef POPCNT_TERNARY_EN
              sign_p1    <= frame_res[RES_W-1];
`else
              sign_p1    <= 1'b0;
`endif
              vld_p1     <= 1'b1;
              acc_p0     <= '0;
              bcnt_p0    <= '0;
              ovf_p0     <= 1'b0;
              in_ready_r <= 1'b0;
              state      <= ST_HOLD;
            end else if (drop) begin
              ovf_p0     <= 1'b1;
            end else begin
              acc_p0     <= frame_res;
              bcnt_p0    <= bcnt_p0 + BCNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            vld_p1     <= 1'b0;
            in_ready_r <= 1'b1;
            state      <= ST_ACC;
          end
        end
        default: begin
          state      <= ST_ACC;
          in_ready_r <= 1'b1;
          vld_p1     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_r;
  assign bus.out_valid    = vld_p1;
  assign bus.popcount_out = res_p1;
  assign bus.out_beats    = beats_p1;
  assign bus.out_ovf      = ovf_p1;
`ifdef POPCNT_TERNARY_EN
  assign bus.out_sign     = sign_p1;
`else
  logic unused_sign;
  assign unused_sign      = sign_p1;
`endif

endmodule

// File: tb/tb_popcount_stream_acc.sv
// Directed bench for popcount_stream_acc: table of single-beat frames plus multi-beat corner sequences.
// Ternary checks are compiled in when POPCNT_TERNARY_EN is defined.
module tb_popcount_stream_acc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  popcount_stream_acc_if #(.IN_W(28), .BEATS_MAX(16)) bus ();

  popcount_stream_acc #(.IN_W(28), .BEATS_MAX(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [27:0] a;
    logic [27:0] b;
    int          exp_cnt;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic signed [63:0] res_val();
    logic signed [63:0] r;
`ifdef POPCNT_TERNARY_EN
    r = $signed(bus.popcount_out);
`else
    r = {55'd0, bus.popcount_out};
`endif
    return r;
  endfunction

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for handshake", nm);
  endtask

  task automatic send_beat(input logic [27:0] a, input logic [27:0] b, input logic last);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.input_a  = a;
`ifdef POPCNT_TERNARY_EN
    bus.input_b  = b;
`else
    if (b != 28'd0) $display("note: input_b ignored in this build");
`endif
    bus.in_last  = last;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) timeout("in_ready_wait");
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.input_a  = '0;
`ifdef POPCNT_TERNARY_EN
    bus.input_b  = '0;
`endif
  endtask

  task automatic take_result(input string nm, input int exp_cnt, input int exp_beats, input logic exp_ovf);
    int n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) timeout({nm, "_out_valid_wait"});
    chk({nm, "_count"}, res_val(), exp_cnt);
    chk({nm, "_beats"}, bus.out_beats, exp_beats);
    chk({nm, "_ovf"}, bus.out_ovf, exp_ovf);
`ifdef POPCNT_TERNARY_EN
    chk({nm, "_sign"}, bus.out_sign, (exp_cnt < 0) ? 1 : 0);
`endif
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    tbl[0] = '{a: 28'hFFFFFFF, b: 28'h0, exp_cnt: 28};
    tbl[1] = '{a: 28'h0000000, b: 28'h0, exp_cnt: 0};
    tbl[2] = '{a: 28'h0000001, b: 28'h0, exp_cnt: 1};
    tbl[3] = '{a: 28'h0000003, b: 28'h0, exp_cnt: 2};
    tbl[4] = '{a: 28'hAAAAAAA, b: 28'h0, exp_cnt: 14};
    tbl[5] = '{a: 28'h8000000, b: 28'h0, exp_cnt: 1};

    bus.in_valid  = 1'b0;
    bus.input_a   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
`ifdef POPCNT_TERNARY_EN
    bus.input_b   = '0;
`endif

    // Reset held two cycles.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_count", res_val(), 0);
    chk("rst_beats", bus.out_beats, 0);
    chk("rst_ovf", bus.out_ovf, 0);
`ifdef POPCNT_TERNARY_EN
    chk("rst_sign", bus.out_sign, 0);
`endif

    // Single-beat frames; result must be visible the cycle after the last beat.
    for (int i = 0; i < 6; i++) begin
      send_beat(tbl[i].a, tbl[i].b, 1'b1);
      chk($sformatf("tbl%0d_latency", i), bus.out_valid, 1);
      take_result($sformatf("tbl%0d", i), tbl[i].exp_cnt, 1, 1'b0);
    end

    // Three-beat frame held under back-pressure.
    send_beat(28'h0000001, 28'h0, 1'b0);
    send_beat(28'h00000FF, 28'h0, 1'b0);
    send_beat(28'hFFFFFFF, 28'h0, 1'b1);
    chk("hold_latency", bus.out_valid, 1);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("hold_count_c%0d", c), res_val(), 37);
      chk($sformatf("hold_in_ready_c%0d", c), bus.in_ready, 0);
      chk($sformatf("hold_beats_c%0d", c), bus.out_beats, 3);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("release_in_ready", bus.in_ready, 1);
    chk("release_out_valid", bus.out_valid, 0);

    // Overflow: 17 full beats, then a last beat; beats past 16 are discarded.
    for (int k = 0; k < 17; k++) send_beat(28'hFFFFFFF, 28'h0, 1'b0);
    send_beat(28'hFFFFFFF, 28'h0, 1'b1);
    take_result("ovf", 448, 16, 1'b1);
    send_beat(28'h0000005, 28'h0, 1'b1);
    take_result("after_ovf", 2, 1, 1'b0);

    // Reset in the middle of a frame discards the partial sum.
    send_beat(28'hFFFFFFF, 28'h0, 1'b0);
    send_beat(28'hFFFFFFF, 28'h0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_out_valid", bus.out_valid, 0);
    send_beat(28'h0000003, 28'h0, 1'b1);
    take_result("midrst", 2, 1, 1'b0);

    // Reset while holding a result clears it.
    send_beat(28'h00000FF, 28'h0, 1'b1);
    chk("holdrst_pre_valid", bus.out_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("holdrst_out_valid", bus.out_valid, 0);
    chk("holdrst_count", res_val(), 0);
    chk("holdrst_in_ready", bus.in_ready, 1);

`ifdef POPCNT_TERNARY_EN
    // Negative-weight bits: 4-8 then 1-0 gives -3.
    send_beat(28'h000000F, 28'h00000FF, 1'b0);
    send_beat(28'h0000001, 28'h0000000, 1'b1);
    take_result("ternary", -3, 2, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
